flash_cache_controller: RTL
===========================

Name: flash_cache_controller

Overview:
- Sequences the flash page cache. Owns SRAM port 0 (write) and SRAM port 1 (read) on behalf of the flash cache requester.
- On a read that misses the cached page, fetches the whole page word-by-word from the QSPI device and writes it into SRAM. It then serves reads from SRAM with a fixed 2-cycle access.
- Sits between the core-side flash cache interface, the QSPI flash device and the dual-port SRAM macro.

Parameters:
- SRAM_ADDRESS_SIZE, 9, SRAM word-address width. Page = 2^SRAM_ADDRESS_SIZE words = 2^(SRAM_ADDRESS_SIZE+2) bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- flashCache_readEnable  in  1  read request; held until busy is low
- flashCache_address  in  24  byte address; bits [1:0] ignored
- flashCache_byteSelect  in  4  ignored; the full word is always returned
- flashCache_invalidate  in  1  single-cycle pulse; drops the cached page
- flashCache_dataRead  out  32  read data; valid when readEnable=1 and busy=0
- flashCache_busy  out  1  request not yet complete
- cacheValid  out  1  status: page resident
- cachedPage  out  24-(SRAM_ADDRESS_SIZE+2)  status: resident page tag
- dataRequest_address  out  24  QSPI word byte address
- dataRequest_enable  out  1  QSPI request
- dataRequest_data  in  32  QSPI returned word
- dataRequest_dataValid  in  1  one-cycle strobe qualifying dataRequest_data
- sram_clk0, sram_csb0, sram_web0  out  1 each  port 0 clock, active-low chip select, active-low write enable
- sram_wmask0  out  4  port 0 write mask
- sram_addr0  out  SRAM_ADDRESS_SIZE  port 0 word address
- sram_din0  out  32  port 0 write data
- sram_dout0  in  32  unused
- sram_clk1, sram_csb1  out  1 each  port 1 clock, active-low chip select
- sram_addr1  out  SRAM_ADDRESS_SIZE  port 1 word address
- sram_dout1  in  32  port 1 read data, valid the cycle after csb1 low

Behaviour:
- tag = address[23:SRAM_ADDRESS_SIZE+2]; index = address[SRAM_ADDRESS_SIZE+1:2].
- hit = cacheValid && tag==cachedPage.
- sram_clk0 = sram_clk1 = clk. sram_wmask0 = 4'b1111.
- Reset (rst=0, async):
  - state = IDLE; cacheValid = 0; cachedPage = 0; fill counter = 0; readPending = 0; invalidatePending = 0.
  - dataRequest_enable = 0; csb0 = 1; web0 = 1; csb1 = 1; busy = readEnable.
  - A reset during a fill aborts it immediately; the page stays invalid.
- IDLE:
  - Hit path (readEnable && hit && !readPending): csb1 = 0, addr1 = index, busy = 1, readPending <= 1.
  - Next cycle (readPending=1): busy = 0, dataRead = sram_dout1, csb1 = 1, readPending <= 0.
  - A read takes exactly 2 cycles. Back-to-back reads issue every other cycle.
  - Miss path (readEnable && !hit): busy = 1. Latch the fill tag = request tag, counter <= 0, go to REQUEST.
- REQUEST:
  - dataRequest_enable = 1; dataRequest_address = {fillTag, counter, 2'b00}; busy = 1.
  - On dataRequest_dataValid in the same cycle: csb0 = 0, web0 = 0, addr0 = counter, din0 = dataRequest_data (combinational pass-through).
  - If counter == all-ones, go to SETTLE; else counter <= counter+1 and go to GAP.
- GAP: one cycle with dataRequest_enable = 0 (explicit request boundary), busy = 1, then return to REQUEST.
- SETTLE:
  - cachedPage <= fillTag; cacheValid <= !invalidatePending; invalidatePending <= 0; busy = 1; go to IDLE.
  - The pending request is then re-evaluated and normally hits.
- dataRequest_enable is low in IDLE and SETTLE.
- dataRequest_address = {fillTag, counter, 2'b00} in every state.
- Invalidate:
  - In IDLE: cacheValid <= 0 next edge. If coincident with a hit issue, that read still completes from SRAM.
  - In REQUEST/GAP: sets invalidatePending; the fill runs to completion but leaves cacheValid = 0.
- readEnable dropped mid-fill: the fill still completes and the page becomes valid.
- readEnable dropped while readPending=1: readPending still clears next cycle.
- Address change while busy is a protocol violation; behaviour is unspecified.
- Fill time = 2^SRAM_ADDRESS_SIZE × (QSPI latency + 1 GAP) + SETTLE + 2-cycle read.

Test Plan:
- SRAM_ADDRESS_SIZE=2, QSPI model returns data = address ^ 32'hA5A5_0000 after 3 cycles. Reset, then read 0x000104 -> requests 0x100, 0x104, 0x108, 0x10C in order, each separated by one enable-low cycle. SRAM writes words 0..3. Then cacheValid=1, cachedPage=0x10, dataRead=0xA5A5_0104 with busy low.
- After that fill, read 0x00010C then 0x000100 back-to-back -> no dataRequest_enable; each returns in 2 cycles with 0xA5A5_010C and 0xA5A5_0100.
- Read 0x000200 after page 0x10 is resident -> refill of page 0x20 (4 requests 0x200..0x20C); cachedPage=0x20.
- Pulse invalidate during the 2nd REQUEST of a fill -> all 4 words fetched, cacheValid stays 0, readEnable still high causes an immediate refill of the same page.
- Assert rst low during GAP of a fill -> same cycle: enable=0, csb0=1, cacheValid=0. After release, the read restarts the fill from word 0.
- Invalidate pulse in IDLE with page resident, no read -> cacheValid=0 next cycle. The next read of the same page refetches 4 words.

Source files
------------

// File: rtl/flash_cache_controller_if.sv
// Core-side flash cache request bus: the requester drives address and
// control, and the cache controller returns read data and busy.
interface flash_cache_controller_if;
    logic        readEnable;
    logic [23:0] address;
    logic [3:0]  byteSelect;
    logic        invalidate;
    logic [31:0] dataRead;
    logic        busy;

    modport master (
        output readEnable, address, byteSelect, invalidate,
        input  dataRead, busy
    );

    modport slave (
        input  readEnable, address, byteSelect, invalidate,
        output dataRead, busy
    );
endinterface

// File: rtl/flash_cache_controller.sv
// Single-page flash cache sequencer. A miss fetches the whole page from the
// QSPI device one word at a time into SRAM port 0. Hits are served from SRAM
// port 1 with a fixed two-cycle access.
module flash_cache_controller #(
    parameter int SRAM_ADDRESS_SIZE = 9
) (
    input  logic                                  clk,
    input  logic                                  rst,
    flash_cache_controller_if.slave               flashCache,
    output logic                                  cacheValid,
    output logic [23-(SRAM_ADDRESS_SIZE+2):0]     cachedPage,
    output logic [23:0]                           dataRequest_address,
    output logic                                  dataRequest_enable,
    input  logic [31:0]                           dataRequest_data,
    input  logic                                  dataRequest_dataValid,
    output logic                                  sram_clk0,
    output logic                                  sram_csb0,
    output logic                                  sram_web0,
    output logic [3:0]                            sram_wmask0,
    output logic [SRAM_ADDRESS_SIZE-1:0]          sram_addr0,
    output logic [31:0]                           sram_din0,
    input  logic [31:0]                           sram_dout0,
    output logic                                  sram_clk1,
    output logic                                  sram_csb1,
    output logic [SRAM_ADDRESS_SIZE-1:0]          sram_addr1,
    input  logic [31:0]                           sram_dout1
);
    localparam int TAG_W = 24 - (SRAM_ADDRESS_SIZE + 2);

    typedef enum logic [1:0] {IDLE, REQUEST, GAP, SETTLE} state_t;

    state_t                       state;
    logic [TAG_W-1:0]             fill_tag;
    logic [SRAM_ADDRESS_SIZE-1:0] fill_count;
    logic                         read_pending;
    logic                         invalidate_pending;

    logic [TAG_W-1:0]             req_tag;
    logic [SRAM_ADDRESS_SIZE-1:0] req_index;
    logic                         hit;
    logic                         unused_inputs;

    assign req_tag   = flashCache.address[23:SRAM_ADDRESS_SIZE+2];
    assign req_index = flashCache.address[SRAM_ADDRESS_SIZE+1:2];
    assign hit       = cacheValid && (req_tag == cachedPage);

    // Port 0 readback, byte lanes and the sub-word address bits play no part:
    // full words are always returned.
    assign unused_inputs = ^{sram_dout0, flashCache.byteSelect, flashCache.address[1:0]};

    assign sram_clk0           = clk;
    assign sram_clk1           = clk;
    assign sram_wmask0         = 4'b1111;
    assign dataRequest_address = {fill_tag, fill_count, 2'b00};

    // Fill sequencing, hit tracking and page status.
    // NOTE: all state here uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cacheValid         <= 1'b0;
            cachedPage         <= '0;
            fill_tag           <= '0;
            fill_count         <= '0;
            read_pending       <= 1'b0;
            invalidate_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_pending) begin
                        read_pending <= 1'b0;
                    end else if (flashCache.readEnable && hit) begin
                        read_pending <= 1'b1;
                    end else if (flashCache.readEnable) begin
                        fill_tag   <= req_tag;
                        fill_count <= '0;
                        state      <= REQUEST;
                    end
                    if (flashCache.invalidate) cacheValid <= 1'b0;
                end
                REQUEST: begin
                    if (flashCache.invalidate) invalidate_pending <= 1'b1;
                    if (dataRequest_dataValid) begin
                        if (fill_count == '1) begin
                            state <= SETTLE;
                        end else begin
                            fill_count <= fill_count + 1'b1;
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (flashCache.invalidate) invalidate_pending <= 1'b1;
                    state <= REQUEST;
                end
                default: begin
                    cachedPage         <= fill_tag;
                    cacheValid         <= !(invalidate_pending || flashCache.invalidate);
                    invalidate_pending <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

    // Strobes and busy follow the current state combinationally so a QSPI
    // word is written into SRAM in the cycle it arrives.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        flashCache.busy     = 1'b1;
        flashCache.dataRead = sram_dout1;
        dataRequest_enable  = 1'b0;
        sram_csb0           = 1'b1;
        sram_web0           = 1'b1;
        sram_addr0          = fill_count;
        sram_din0           = dataRequest_data;
        sram_csb1           = 1'b1;
        sram_addr1          = req_index;
        case (state)
            IDLE: begin
                if (read_pending) begin
                    flashCache.busy = 1'b0;
                end else begin
                    flashCache.busy = flashCache.readEnable;
                    if (flashCache.readEnable && hit) sram_csb1 = 1'b0;
                end
            end
            REQUEST: begin
                dataRequest_enable = 1'b1;
                if (dataRequest_dataValid) begin
                    sram_csb0 = 1'b0;
                    sram_web0 = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule
